// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: pixel/line counters with sync, blank,
// frame-start tick and a wrapping frame counter, all registered on pclk.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLNK_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLNK_START = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Half-open window test [lo, hi) used for both sync pulses.
  function automatic logic in_window(input logic [10:0] cnt,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  logic        h_wrap;
  logic        v_wrap;
  logic        frame_start;
  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;

  // Wrap tests use >= so a corrupted count falls back to 0 at the next compare.
  always_comb begin
    h_wrap      = (hcount_out >= H_LAST);
    v_wrap      = (vcount_out >= V_LAST);
    hcount_nxt  = h_wrap ? 11'd0 : hcount_out + 11'd1;
    vcount_nxt  = vcount_out;
    if (h_wrap) begin
      vcount_nxt = v_wrap ? 11'd0 : vcount_out + 11'd1;
    end
    frame_start = (hcount_nxt == 11'd0) && (vcount_nxt == 11'd0);
  end

  // Decodes act on the next-state counts so they land in the same cycle as the counts.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      hcount_out <= hcount_nxt;
      vcount_out <= vcount_nxt;
      hblnk_out  <= (hcount_nxt >= H_BLNK_START);
      hsync_out  <= in_window(hcount_nxt, H_SYNC_START, H_SYNC_END);
      vblnk_out  <= (vcount_nxt >= V_BLNK_START);
      vsync_out  <= in_window(vcount_nxt, V_SYNC_START, V_SYNC_END);
      frame_tick <= frame_start;
      if (frame_start) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen with a cycle-count reference model;
// horizontal timing uses the default parameters, vertical timing is shortened.
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int V_ACTIVE = 3;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = HT * VT;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic [10:0] hcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic [10:0] vcount_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic        frame_tick;
  logic [15:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: m_t counts edges since reset release; raster position is plain arithmetic on it.
  bit          m_rst = 1'b1;
  int          m_t   = 0;
  logic [15:0] m_fc  = 16'd0;

  always @(posedge pclk) begin
    if (!rst) begin
      m_rst = 1'b1;
      m_t   = 0;
      m_fc  = 16'd0;
    end else begin
      m_rst = 1'b0;
      m_t   = m_t + 1;
      if (m_t % FRAME == 0) m_fc = m_fc + 16'd1;
    end
  end

  function automatic int exp_h();
    return m_rst ? 0 : m_t % HT;
  endfunction

  function automatic int exp_v();
    return m_rst ? 0 : (m_t / HT) % VT;
  endfunction

  int tick_cnt  = 0;
  int last_tick = 0;
  bit have_tick = 1'b0;
  int hs_run    = 0;
  bit prev_hs   = 1'b0;

  always @(negedge pclk) begin
    int  eh, ev;
    bit  ehs, ehb, evs, evb, etk;
    eh  = exp_h();
    ev  = exp_v();
    ehb = !m_rst && (eh >= H_ACTIVE);
    ehs = !m_rst && (eh >= H_ACTIVE + H_FP) && (eh < H_ACTIVE + H_FP + H_SYNC);
    evb = !m_rst && (ev >= V_ACTIVE);
    evs = !m_rst && (ev >= V_ACTIVE + V_FP) && (ev < V_ACTIVE + V_FP + V_SYNC);
    etk = !m_rst && (eh == 0) && (ev == 0);
    check("hcount", 32'(hcount_out), 32'(eh));
    check("vcount", 32'(vcount_out), 32'(ev));
    check("hblnk",  32'(hblnk_out),  32'(ehb));
    check("hsync",  32'(hsync_out),  32'(ehs));
    check("vblnk",  32'(vblnk_out),  32'(evb));
    check("vsync",  32'(vsync_out),  32'(evs));
    check("tick",   32'(frame_tick), 32'(etk));
    check("fcnt",   32'(frame_cnt),  32'(m_fc));

    if (m_rst) begin
      have_tick = 1'b0;
      hs_run    = 0;
      prev_hs   = 1'b0;
    end else begin
      if (frame_tick === 1'b1) begin
        tick_cnt++;
        if (have_tick) check("tick_gap", 32'(m_t - last_tick), 32'(FRAME));
        last_tick = m_t;
        have_tick = 1'b1;
      end
      if (hsync_out === 1'b1 && !prev_hs)
        check("hsync_start", 32'(hcount_out), 32'(H_ACTIVE + H_FP));
      if (hsync_out === 1'b1) hs_run++;
      if (hsync_out !== 1'b1 && prev_hs) begin
        check("hsync_len", 32'(hs_run), 32'(H_SYNC));
        hs_run = 0;
      end
      prev_hs = (hsync_out === 1'b1);
    end
  end

  task automatic wait_pos(input int h, input int v, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (!m_rst && exp_h() == h && exp_v() == v) begin
        hit = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    bit hit;
    rst = 1'b0;
    repeat (4) @(negedge pclk);
    rst = 1'b1;
    tick_cnt = 0;

    // Three full frames from reset release.
    repeat (3 * FRAME + 10) @(negedge pclk);
    check("ticks_3frames", 32'(tick_cnt), 32'd3);
    check("fcnt_3frames", 32'(frame_cnt), 32'd3);

    // Reset in the middle of the horizontal sync on a vertical-sync line.
    wait_pos(900, V_ACTIVE + V_FP + 1, "wait_mid_frame");
    rst = 1'b0;
    @(negedge pclk);
    check("midrst_h", 32'(hcount_out), 32'd0);
    check("midrst_v", 32'(vcount_out), 32'd0);
    check("midrst_hs", 32'(hsync_out), 32'd0);
    check("midrst_vs", 32'(vsync_out), 32'd0);
    rst = 1'b1;
    @(negedge pclk);
    check("restart_h", 32'(hcount_out), 32'd1);
    check("restart_v", 32'(vcount_out), 32'd0);
    check("restart_tick", 32'(frame_tick), 32'd0);

    // Random reset pulses at random raster positions.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(FRAME / 2, 1)) @(negedge pclk);
      rst = 1'b0;
      repeat ($urandom_range(3, 1)) @(negedge pclk);
      rst = 1'b1;
    end
    repeat (HT + 100) @(negedge pclk);

    // Frame counter wrap from all-ones.
    wait_pos(500, 1, "wait_force_point");
    #2;
    force dut.frame_cnt = 16'hFFFF;
    m_fc = 16'hFFFF;
    @(negedge pclk);
    #2;
    release dut.frame_cnt;
    hit = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge pclk);
      if (!m_rst && m_t % FRAME == 0) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_wrap_tick", 32'(hit), 32'd1);
    check("fcnt_wrap", 32'(frame_cnt), 32'd0);
    check("wrap_tick", 32'(frame_tick), 32'd1);
    repeat (20) @(negedge pclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
